// File: rtl/dot_prod_peak.sv
// dot_prod_peak: streaming peak search over windows of complex dot-product results.
// Each accepted (i, q) passes through a 3-stage pipeline: squares, power sum, then a running
// max compare. One peak record (power, index) is presented per window and held until the
// downstream logic accepts it.
module dot_prod_peak #(
    parameter int unsigned i_bits     = 24,
    parameter int unsigned q_bits     = 24,
    parameter int unsigned num_shifts = 8,
    parameter int unsigned index_bits = 3,
    parameter int unsigned power_bits = 2 * i_bits
) (
    input  logic                         clk,
    input  logic                         n_reset,
    input  logic                         s_axis_product_tvalid,
    output logic                         m_axis_product_tready,
    input  logic signed [i_bits-1:0]     i,
    input  logic signed [q_bits-1:0]     q,
    input  logic                         m_axis_peak_tready,
    output logic                         s_axis_peak_tvalid,
    output logic [power_bits-1:0]        peak_power,
    output logic [index_bits-1:0]        peak_index
);

    localparam logic [1:0] StAccum   = 2'd0;
    localparam logic [1:0] StDrain   = 2'd1;
    localparam logic [1:0] StPresent = 2'd2;

    localparam logic [index_bits-1:0] LastIdx = index_bits'(num_shifts - 1);

    logic [1:0]                    state_q, state_d;
    logic                          tready_q;
    logic                          peak_valid_q;
    logic [power_bits-1:0]         peak_power_q;
    logic [index_bits-1:0]         peak_index_q;
    logic [index_bits-1:0]         in_idx_q;

    logic                          s1_valid_q;
    logic signed [power_bits-1:0]  s1_ii_q, s1_qq_q;
    logic [index_bits-1:0]         s1_idx_q;

    logic                          s2_valid_q;
    logic [power_bits-1:0]         s2_power_q;
    logic [index_bits-1:0]         s2_idx_q;

    logic [power_bits-1:0]         max_q;
    logic [index_bits-1:0]         max_idx_q;

    logic                          accept;
    logic                          release_rec;
    logic                          finish;
    logic                          take;
    logic [power_bits-1:0]         new_max;
    logic [index_bits-1:0]         new_idx;
    logic signed [power_bits-1:0]  i_ext, q_ext;

    // Sign-extend before squaring so the products are formed at full width.
    assign i_ext = {{(power_bits - i_bits){i[i_bits-1]}}, i};
    assign q_ext = {{(power_bits - q_bits){q[q_bits-1]}}, q};

    assign accept      = s_axis_product_tvalid & tready_q;
    assign release_rec = (state_q == StPresent) & m_axis_peak_tready;
    assign finish      = s2_valid_q & (s2_idx_q == LastIdx) & (state_q == StDrain);

    // Stage-3 compare: strict greater-than keeps the lowest index on ties; idx 0 always loads.
    always_comb begin
        take    = s2_valid_q & ((s2_idx_q == '0) | (s2_power_q > max_q));
        new_max = take ? s2_power_q : max_q;
        new_idx = take ? s2_idx_q : max_idx_q;
    end

    // Window control: accumulate, drain the pipeline, then present the record.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StAccum:   if (accept && in_idx_q == LastIdx) state_d = StDrain;
            StDrain:   if (finish) state_d = StPresent;
            StPresent: if (m_axis_peak_tready) state_d = StAccum;
            default:   state_d = StAccum;
        endcase
    end

    // Control state, handshake outputs and input index counter.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q      <= StAccum;
            tready_q     <= 1'b0;
            peak_valid_q <= 1'b0;
            in_idx_q     <= '0;
        end else begin
            state_q      <= state_d;
            tready_q     <= (state_d == StAccum);
            peak_valid_q <= (state_d == StPresent);
            // The index saturates on the last sample; only a released record rewinds it.
            if (release_rec) begin
                in_idx_q <= '0;
            end else if (accept && in_idx_q != LastIdx) begin
                in_idx_q <= in_idx_q + 1'b1;
            end
        end
    end

    // Stages 1 and 2: squares, then the unsigned power sum.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            s1_valid_q <= 1'b0;
            s1_ii_q    <= '0;
            s1_qq_q    <= '0;
            s1_idx_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_power_q <= '0;
            s2_idx_q   <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_ii_q  <= i_ext * i_ext;
                s1_qq_q  <= q_ext * q_ext;
                s1_idx_q <= in_idx_q;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_power_q <= $unsigned(s1_ii_q) + $unsigned(s1_qq_q);
                s2_idx_q   <= s1_idx_q;
            end
        end
    end

    // Stage 3: running max, and the held peak record.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            max_q        <= '0;
            max_idx_q    <= '0;
            peak_power_q <= '0;
            peak_index_q <= '0;
        end else begin
            if (release_rec) begin
                max_q     <= '0;
                max_idx_q <= '0;
            end else if (s2_valid_q) begin
                max_q     <= new_max;
                max_idx_q <= new_idx;
            end
            if (finish) begin
                peak_power_q <= new_max;
                peak_index_q <= new_idx;
            end
        end
    end

    assign m_axis_product_tready = tready_q;
    assign s_axis_peak_tvalid    = peak_valid_q;
    assign peak_power            = peak_power_q;
    assign peak_index            = peak_index_q;

endmodule

// File: tb/tb_dot_prod_peak.sv
// tb_dot_prod_peak: directed and randomized windows checked against a plain-arithmetic
// peak model (num_shifts = 4).
module tb_dot_prod_peak;

    localparam int IB = 24;
    localparam int NS = 4;
    localparam int XB = 2;
    localparam int PB = 48;

    logic                 clk = 1'b0;
    logic                 n_reset;
    logic                 s_axis_product_tvalid;
    logic                 m_axis_product_tready;
    logic signed [IB-1:0] i;
    logic signed [IB-1:0] q;
    logic                 m_axis_peak_tready;
    logic                 s_axis_peak_tvalid;
    logic [PB-1:0]        peak_power;
    logic [XB-1:0]        peak_index;

    int n_checks = 0;
    int n_pass   = 0;

    logic signed [IB-1:0] win_i [NS];
    logic signed [IB-1:0] win_q [NS];

    always #5 clk = ~clk;

    dot_prod_peak #(
        .i_bits     (IB),
        .q_bits     (IB),
        .num_shifts (NS),
        .index_bits (XB),
        .power_bits (PB)
    ) dut (
        .clk                   (clk),
        .n_reset               (n_reset),
        .s_axis_product_tvalid (s_axis_product_tvalid),
        .m_axis_product_tready (m_axis_product_tready),
        .i                     (i),
        .q                     (q),
        .m_axis_peak_tready    (m_axis_peak_tready),
        .s_axis_peak_tvalid    (s_axis_peak_tvalid),
        .peak_power            (peak_power),
        .peak_index            (peak_index)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference: power = i^2 + q^2 in 64-bit integers; first strict maximum wins.
    task automatic model(output logic [PB-1:0] p, output logic [XB-1:0] x);
        longint best = -1;
        int     bi   = 0;
        for (int k = 0; k < NS; k++) begin
            longint pw = longint'(win_i[k]) * longint'(win_i[k])
                       + longint'(win_q[k]) * longint'(win_q[k]);
            if (pw > best) begin
                best = pw;
                bi   = k;
            end
        end
        p = PB'(best);
        x = XB'(bi);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one result after 'gap' idle cycles and wait (bounded) for its accept.
    task automatic send(input logic signed [IB-1:0] vi, input logic signed [IB-1:0] vq,
                        input int gap);
        logic tr;
        int   waited = 0;
        bit   done   = 0;
        repeat (gap) begin
            s_axis_product_tvalid = 1'b0;
            i = IB'($urandom);
            tick();
        end
        s_axis_product_tvalid = 1'b1;
        i = vi;
        q = vq;
        while (!done) begin
            tr = m_axis_product_tready;
            tick();
            if (tr) done = 1;
            else if (++waited > 50) begin
                check("accept_timeout", 64'd0, 64'd1);
                done = 1;
            end
        end
        s_axis_product_tvalid = 1'b0;
    endtask

    task automatic run_window(input string tag, input int max_gap, input int hold);
        logic [PB-1:0] ep;
        logic [XB-1:0] ex;
        model(ep, ex);
        m_axis_peak_tready = (hold == 0);
        for (int k = 0; k < NS; k++) send(win_i[k], win_q[k], $urandom_range(0, max_gap));
        check({tag, "_e0_valid"}, 64'(s_axis_peak_tvalid), 64'd0);
        check({tag, "_e0_ready"}, 64'(m_axis_product_tready), 64'd0);
        tick();
        check({tag, "_e1_valid"}, 64'(s_axis_peak_tvalid), 64'd0);
        tick();
        check({tag, "_e2_valid"}, 64'(s_axis_peak_tvalid), 64'd1);
        check({tag, "_power"}, 64'(peak_power), 64'(ep));
        check({tag, "_index"}, 64'(peak_index), 64'(ex));
        if (hold > 0) begin
            s_axis_product_tvalid = 1'b1;
            i = IB'($urandom);
            q = IB'($urandom);
            repeat (hold) begin
                tick();
                check({tag, "_hold_valid"}, 64'(s_axis_peak_tvalid), 64'd1);
                check({tag, "_hold_power"}, 64'(peak_power), 64'(ep));
                check({tag, "_hold_index"}, 64'(peak_index), 64'(ex));
                check({tag, "_hold_ready"}, 64'(m_axis_product_tready), 64'd0);
            end
            s_axis_product_tvalid = 1'b0;
            m_axis_peak_tready = 1'b1;
        end
        tick();
        check({tag, "_rel_valid"}, 64'(s_axis_peak_tvalid), 64'd0);
        check({tag, "_rel_ready"}, 64'(m_axis_product_tready), 64'd1);
    endtask

    task automatic set_win(input int k, input int vi, input int vq);
        win_i[k] = IB'(vi);
        win_q[k] = IB'(vq);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(m_axis_product_tready), 64'd0);
        check({tag, "_valid"}, 64'(s_axis_peak_tvalid), 64'd0);
        check({tag, "_power"}, 64'(peak_power), 64'd0);
        check({tag, "_index"}, 64'(peak_index), 64'd0);
    endtask

    initial begin
        n_reset               = 1'b0;
        s_axis_product_tvalid = 1'b0;
        m_axis_peak_tready    = 1'b0;
        i                     = '0;
        q                     = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        n_reset = 1'b1;
        tick();
        check("reset_release_ready", 64'(m_axis_product_tready), 64'd1);

        set_win(0, 3, 4); set_win(1, 0, -5); set_win(2, 6, 0); set_win(3, -2, 2);
        run_window("basic", 0, 0);

        set_win(0, 5, 0); set_win(1, 0, 5); set_win(2, 3, 4); set_win(3, -4, -3);
        run_window("tie", 0, 0);

        set_win(0, 0, 0); set_win(1, -8388608, -8388608); set_win(2, 0, 0); set_win(3, 0, 0);
        run_window("extreme", 0, 0);

        set_win(0, 3, 4); set_win(1, 0, -5); set_win(2, 6, 0); set_win(3, -2, 2);
        run_window("backpressure", 0, 5);
        run_window("bubbles", 3, 0);

        // Reset mid-window: two results in flight are discarded.
        m_axis_peak_tready = 1'b0;
        send(24'sd100, 24'sd100, 0);
        send(24'sd200, 24'sd0, 0);
        n_reset = 1'b0;
        tick();
        check_reset_outputs("midreset");
        n_reset = 1'b1;
        tick();
        check("midreset_release_ready", 64'(m_axis_product_tready), 64'd1);
        set_win(0, 1, 0); set_win(1, 0, 2); set_win(2, 0, 0); set_win(3, 1, 1);
        run_window("fresh", 0, 0);

        for (int w = 0; w < 24; w++) begin
            for (int k = 0; k < NS; k++) begin
                if (w % 2 == 0) set_win(k, $urandom_range(0, 6) - 3, $urandom_range(0, 6) - 3);
                else set_win(k, int'($urandom), int'($urandom));
            end
            run_window("random", $urandom_range(0, 3), (w % 3 == 0) ? $urandom_range(1, 4) : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dot_prod_peak.md
Name: dot_prod_peak

Overview:
Streaming consumer at the output of the pipelined dot-product engine. It accepts one complex dot-product result (i, q) per handshake and computes power = i^2 + q^2. It scans a window of num_shifts consecutive results, tracking the maximum power and its index (the winning shift/lag). It presents one peak record per window to the downstream CAF search logic, holding it until that logic accepts it.

Parameters:
i_bits, 24, width of signed input i (two's complement)
q_bits, 24, width of signed input q; must equal i_bits
num_shifts, 8, number of dot-product results per search window (>=1)
index_bits, 3, width of peak_index; 2^index_bits >= num_shifts
power_bits, 48, width of unsigned power; fixed to 2*i_bits

Ports:
clk  input  1  rising-edge clock
n_reset  input  1  synchronous active-low reset, sampled on rising edge of clk
s_axis_product_tvalid  input  1  upstream result valid
m_axis_product_tready  output  1  block ready to accept a result
i  input  i_bits  signed real part of dot product
q  input  q_bits  signed imaginary part of dot product
m_axis_peak_tready  input  1  downstream ready for peak record
s_axis_peak_tvalid  output  1  peak record valid
peak_power  output  power_bits  unsigned max i^2+q^2 in window
peak_index  output  index_bits  0-based position of peak within window

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (n_reset). No other reset or clock.
- Reset (n_reset low at an edge):
  - all outputs go to 0: m_axis_product_tready=0, s_axis_peak_tvalid=0, peak_power=0, peak_index=0
  - pipeline valids, counters and running max are cleared; state=ACCUM
  - m_axis_product_tready rises on the first edge with n_reset high
- Accept: a result is accepted on an edge where s_axis_product_tvalid & m_axis_product_tready are both 1. Cycles with tvalid low are bubbles: no index advance, no state change.
- Pipeline (accepting edge = E):
  - E: stage1 registers signed products i*i and q*q, plus in_idx (0..num_shifts-1)
  - E+1: stage2 registers power = unsigned sum (power_bits wide) and idx
  - E+2: stage3 compares against running max
- Max update:
  - running max is replaced only if power > max (strict compare), so on ties the lowest index wins
  - the first result of a window (idx 0) always loads, regardless of value
- Arithmetic: products are computed at full width. Worst case (-2^(i_bits-1))^2 * 2 = 2^(2*i_bits-1) fits power_bits with no wrap or saturation.
- State machine:
  - ACCUM: tready=1. On the edge accepting idx num_shifts-1, go to DRAIN; tready drops after that edge.
  - DRAIN: tready=0. Wait until stage3 processes the last sample (edge E+2). On that edge, load peak_power/peak_index with the final max (including the last sample), set s_axis_peak_tvalid=1, go to PRESENT.
  - PRESENT: tvalid=1, tready=0. peak_power/peak_index are stable while held. On an edge with m_axis_peak_tready=1: tvalid=0, clear max and in_idx, go to ACCUM (tready=1 after that edge).
- Latency: s_axis_peak_tvalid is high after edge E+2, where E accepts the final sample. Minimum window period is num_shifts+3 cycles.
- Boundary conditions:
  - results offered while tready=0 are not consumed; upstream must hold or drop them
  - with num_shifts=1, every accepted result yields a record, with peak_index=0
  - in_idx wraps to 0 only via the PRESENT->ACCUM transition, never by overflow
  - reset mid-window or mid-PRESENT discards partial results; pipeline stages in flight are squashed
  - m_axis_peak_tready high outside PRESENT has no effect

Test Plan:
- num_shifts=4; results (3,4),(0,-5),(6,0),(-2,2), back-to-back -> peak_power=36, peak_index=2; tvalid high 2 edges after the 4th accept.
- Tie: (5,0),(0,5),(3,4),(-4,-3) -> peak_power=25, peak_index=0.
- Extreme: i=q=-8388608 at idx1, others 0 -> peak_power=140737488355328 (2^47), peak_index=1, no wrap.
- Backpressure: hold m_axis_peak_tready low 5 cycles -> tvalid and record stable, m_axis_product_tready=0, input tvalid ignored; on accept, tready=1 the next cycle and the next window starts at idx0.
- Bubbles: 4 results separated by 0-3 idle cycles -> same record as scenario 1; index counts only accepts.
- Reset mid-window: 2 results accepted, n_reset low 1 cycle -> all outputs 0; a fresh 4-result window (1,0),(0,2),(0,0),(1,1) -> peak_power=4, peak_index=1.
